// File: rtl/snoop_bus_if.sv
// Bundle of cache-side request/response signals and the shared RAM port of
// the snoop bus arbiter. The slave modport is the arbiter's view. The master
// modport is the view of the caches and RAM that drive the arbiter.
interface snoop_bus_if #(
    parameter int NCPU = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    // cache -> arbiter
    logic [NCPU-1:0]          iren;
    logic [NCPU-1:0]          dren;
    logic [NCPU-1:0]          dwen;
    logic [NCPU-1:0][AW-1:0]  iaddr;
    logic [NCPU-1:0][AW-1:0]  daddr;
    logic [NCPU-1:0][DW-1:0]  dstore;
    logic [NCPU-1:0]          ccwrite;
    logic [NCPU-1:0]          ccdirty;

    // arbiter -> cache
    logic [NCPU-1:0]          iwait;
    logic [NCPU-1:0]          dwait;
    logic [NCPU-1:0][DW-1:0]  iload;
    logic [NCPU-1:0][DW-1:0]  dload;
    logic [NCPU-1:0]          ccwait;
    logic [NCPU-1:0]          ccinv;
    logic [NCPU-1:0][AW-1:0]  ccsnoopaddr;

    // arbiter <-> RAM
    logic [AW-1:0]            ramaddr;
    logic [DW-1:0]            ramstore;
    logic                     ramren;
    logic                     ramwen;
    logic [DW-1:0]            ramload;
    logic [1:0]               ramstate;

    modport slave (
        input  iren, dren, dwen, iaddr, daddr, dstore, ccwrite, ccdirty,
        input  ramload, ramstate,
        output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
        output ramaddr, ramstore, ramren, ramwen
    );

    modport master (
        output iren, dren, dwen, iaddr, daddr, dstore, ccwrite, ccdirty,
        output ramload, ramstate,
        input  iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
        input  ramaddr, ramstore, ramren, ramwen
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter for NCPU cache pairs sharing one RAM port. It serves
// instruction fetches, data writes and data reads. Every data read is preceded
// by a single snoop cycle. A dirty peer cache supplies the line
// cache-to-cache and flushes it to RAM at the same time.
module snoop_bus_arbiter #(
    parameter int NCPU = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    snoop_bus_if.slave  bus
);
    localparam int         GW         = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IFETCH,
        S_DWRITE,
        S_SNOOP,
        S_C2C,
        S_M2C
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   own_q, own_d;
    logic [GW-1:0]   rr_q, rr_d;

    logic [NCPU-1:0] req_any;
    logic [NCPU-1:0] dirty_other;
    logic            rr_found;
    logic [GW-1:0]   rr_sel;
    logic            own_found;
    logic [GW-1:0]   own_sel;
    logic [GW-1:0]   gnt_next;
    logic            ram_busy;

    // Output staging, copied onto the interface with continuous assigns
    logic [NCPU-1:0]         iwait_c, dwait_c, ccwait_c, ccinv_c;
    logic [NCPU-1:0][DW-1:0] iload_c, dload_c;
    logic [NCPU-1:0][AW-1:0] ccsnoopaddr_c;
    logic [AW-1:0]           ramaddr_c;
    logic [DW-1:0]           ramstore_c;
    logic                    ramren_c, ramwen_c;

    // ERROR and FREE count as "not done". Only ACCESS releases a stalled cache.
    assign ram_busy = (bus.ramstate != RAM_ACCESS);

    // Pointer to the cache after the current grant. It wraps at NCPU, so
    // non-power-of-two counts work.
    assign gnt_next = (gnt_q == GW'(NCPU - 1)) ? '0 : gnt_q + GW'(1);

    // Per-cache summaries: the cache has any request, or the cache is a dirty
    // peer of the granted cache.
    generate
        for (genvar gi = 0; gi < NCPU; gi++) begin : g_cache
            assign req_any[gi]     = bus.iren[gi] | bus.dren[gi] | bus.dwen[gi];
            assign dirty_other[gi] = bus.ccdirty[gi] && (GW'(gi) != gnt_q);
        end
    endgenerate

    // Round-robin pick: the first requesting cache at or after rr_q, modulo NCPU
    always_comb begin
        int idx;
        rr_found = 1'b0;
        rr_sel   = '0;
        idx      = 0;
        for (int k = 0; k < NCPU; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NCPU) begin
                idx = idx - NCPU;
            end
            if (!rr_found && req_any[idx]) begin
                rr_found = 1'b1;
                rr_sel   = GW'(idx);
            end
        end
    end

    // Owner pick: the lowest-indexed dirty peer. Scanning downward lets the
    // lowest index win.
    always_comb begin
        own_found = 1'b0;
        own_sel   = '0;
        for (int k = NCPU - 1; k >= 0; k--) begin
            if (dirty_other[k]) begin
                own_found = 1'b1;
                own_sel   = GW'(k);
            end
        end
    end

    // State, grant, owner and round-robin registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
        end
    end

    // Next-state logic. The pointer advances past the served cache on every
    // return to IDLE.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        own_d   = own_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    gnt_d = rr_sel;
                    if (bus.dwen[rr_sel]) begin
                        state_d = S_DWRITE;
                    end else if (bus.dren[rr_sel]) begin
                        state_d = S_SNOOP;
                    end else begin
                        state_d = S_IFETCH;
                    end
                end
            end
            S_IFETCH: begin
                if (!bus.iren[gnt_q]) begin
                    state_d = S_IDLE;
                    rr_d    = gnt_next;
                end
            end
            S_DWRITE: begin
                if (!bus.dwen[gnt_q]) begin
                    state_d = S_IDLE;
                    rr_d    = gnt_next;
                end
            end
            S_SNOOP: begin
                // Always exactly one cycle, even if the requester has already dropped
                if (own_found) begin
                    state_d = S_C2C;
                    own_d   = own_sel;
                end else begin
                    state_d = S_M2C;
                end
            end
            S_C2C, S_M2C: begin
                if (!bus.dren[gnt_q]) begin
                    state_d = S_IDLE;
                    rr_d    = gnt_next;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode. Any requesting cache that is not being served sees its
    // wait bit set. Everything else stays 0 unless the state drives it.
    always_comb begin
        iwait_c       = bus.iren;
        dwait_c       = bus.dren | bus.dwen;
        iload_c       = '0;
        dload_c       = '0;
        ccwait_c      = '0;
        ccinv_c       = '0;
        ccsnoopaddr_c = '0;
        ramaddr_c     = '0;
        ramstore_c    = '0;
        ramren_c      = 1'b0;
        ramwen_c      = 1'b0;
        if (!rst_n) begin
            iwait_c = '0;
            dwait_c = '0;
        end else begin
            case (state_q)
                S_IFETCH: begin
                    ramren_c        = 1'b1;
                    ramaddr_c       = bus.iaddr[gnt_q];
                    iload_c[gnt_q]  = bus.ramload;
                    iwait_c[gnt_q]  = ram_busy;
                end
                S_DWRITE: begin
                    ramwen_c        = 1'b1;
                    ramaddr_c       = bus.daddr[gnt_q];
                    ramstore_c      = bus.dstore[gnt_q];
                    dwait_c[gnt_q]  = ram_busy;
                end
                S_SNOOP: begin
                    for (int k = 0; k < NCPU; k++) begin
                        if (GW'(k) != gnt_q) begin
                            ccwait_c[k]      = 1'b1;
                            ccsnoopaddr_c[k] = bus.daddr[gnt_q];
                            ccinv_c[k]       = bus.ccwrite[gnt_q];
                        end
                    end
                end
                S_C2C: begin
                    // The owner supplies the line and writes it back in the same transfer
                    ccwait_c[own_q] = 1'b1;
                    ramwen_c        = 1'b1;
                    ramaddr_c       = bus.daddr[own_q];
                    ramstore_c      = bus.dstore[own_q];
                    dload_c[gnt_q]  = bus.dstore[own_q];
                    dwait_c[gnt_q]  = ram_busy;
                    dwait_c[own_q]  = ram_busy;
                end
                S_M2C: begin
                    ramren_c        = 1'b1;
                    ramaddr_c       = bus.daddr[gnt_q];
                    dload_c[gnt_q]  = bus.ramload;
                    dwait_c[gnt_q]  = ram_busy;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.iwait       = iwait_c;
    assign bus.dwait       = dwait_c;
    assign bus.iload       = iload_c;
    assign bus.dload       = dload_c;
    assign bus.ccwait      = ccwait_c;
    assign bus.ccinv       = ccinv_c;
    assign bus.ccsnoopaddr = ccsnoopaddr_c;
    assign bus.ramaddr     = ramaddr_c;
    assign bus.ramstore    = ramstore_c;
    assign bus.ramren      = ramren_c;
    assign bus.ramwen      = ramwen_c;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter with four caches. The caches and the RAM are
// modelled at transaction level. Pending request bits per cache and a
// round-robin index decide which cache is served next and how. Every cycle's
// outputs are compared with the values that the served transaction implies.
module tb_snoop_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    // phase codes used by the bench only
    localparam int PH_IDLE = 0, PH_IF = 1, PH_DW = 2, PH_SN = 3, PH_C2C = 4, PH_M2C = 5, PH_RST = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    logic [N-1:0] pi, pr, pw;   // pending iREN / dREN / dWEN per cache
    int           rr;           // reference round-robin start index
    bit           fix_load;

    snoop_bus_if #(.NCPU(N), .AW(AW), .DW(DW)) bus ();

    snoop_bus_arbiter #(.NCPU(N), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.iren = pi;
        bus.dren = pr;
        bus.dwen = pw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every output with the values that phase ph implies for grant g and owner o
    task automatic expect_cycle(input int ph, input int g, input int o);
        logic [N-1:0]         e_iw, e_dw, e_ccw, e_cci;
        logic [N-1:0][DW-1:0] e_il, e_dl;
        logic [N-1:0][AW-1:0] e_csa;
        logic [AW-1:0]        e_ra;
        logic [DW-1:0]        e_rs;
        logic                 e_ren, e_wen, busy;
        busy  = (bus.ramstate != ST_ACCESS);
        e_iw  = bus.iren;
        e_dw  = bus.dren | bus.dwen;
        e_ccw = '0; e_cci = '0; e_il = '0; e_dl = '0; e_csa = '0;
        e_ra  = '0; e_rs = '0; e_ren = 1'b0; e_wen = 1'b0;
        case (ph)
            PH_IF: begin
                e_ren = 1'b1; e_ra = bus.iaddr[g]; e_il[g] = bus.ramload; e_iw[g] = busy;
            end
            PH_DW: begin
                e_wen = 1'b1; e_ra = bus.daddr[g]; e_rs = bus.dstore[g]; e_dw[g] = busy;
            end
            PH_SN: begin
                for (int i = 0; i < N; i++) begin
                    if (i != g) begin
                        e_ccw[i] = 1'b1;
                        e_csa[i] = bus.daddr[g];
                        e_cci[i] = bus.ccwrite[g];
                    end
                end
            end
            PH_C2C: begin
                e_ccw[o] = 1'b1; e_wen = 1'b1; e_ra = bus.daddr[o]; e_rs = bus.dstore[o];
                e_dl[g] = bus.dstore[o]; e_dw[g] = busy; e_dw[o] = busy;
            end
            PH_M2C: begin
                e_ren = 1'b1; e_ra = bus.daddr[g]; e_dl[g] = bus.ramload; e_dw[g] = busy;
            end
            PH_RST: begin
                e_iw = '0; e_dw = '0;
            end
            default: begin
            end
        endcase
        check_eq($sformatf("iwait ph%0d", ph),   128'(bus.iwait),       128'(e_iw));
        check_eq($sformatf("dwait ph%0d", ph),   128'(bus.dwait),       128'(e_dw));
        check_eq($sformatf("iload ph%0d", ph),   128'(bus.iload),       128'(e_il));
        check_eq($sformatf("dload ph%0d", ph),   128'(bus.dload),       128'(e_dl));
        check_eq($sformatf("ccwait ph%0d", ph),  128'(bus.ccwait),      128'(e_ccw));
        check_eq($sformatf("ccinv ph%0d", ph),   128'(bus.ccinv),       128'(e_cci));
        check_eq($sformatf("snpaddr ph%0d", ph), 128'(bus.ccsnoopaddr), 128'(e_csa));
        check_eq($sformatf("ramaddr ph%0d", ph), 128'(bus.ramaddr),     128'(e_ra));
        check_eq($sformatf("ramstore ph%0d", ph),128'(bus.ramstore),    128'(e_rs));
        check_eq($sformatf("ramren ph%0d", ph),  128'(bus.ramren),      128'(e_ren));
        check_eq($sformatf("ramwen ph%0d", ph),  128'(bus.ramwen),      128'(e_wen));
    endtask

    task automatic sample(input int ph, input int g, input int o);
        @(negedge clk);
        expect_cycle(ph, g, o);
    endtask

    task automatic rand_fields();
        logic [31:0] r;
        for (int c = 0; c < N; c++) begin
            r = $urandom; bus.iaddr[c]  = {r[31:2], 2'(c)};
            r = $urandom; bus.daddr[c]  = {r[31:2], 2'(c)};
            r = $urandom; bus.dstore[c] = r;
        end
        bus.ccwrite = 4'($urandom_range(0, 15));
        bus.ccdirty = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
    endtask

    // One full transaction: the cache chosen by the reference round robin is
    // served with its highest-priority request. busy_n is the number of
    // BUSY/ERROR cycles before ACCESS (-1 = random). drop_snoop makes the
    // requester give up during the snoop cycle.
    task automatic run_txn(input int busy_n, input bit drop_snoop);
        int    g, o, ph, b;
        string kind;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (rr + k) % N;
            if (g < 0 && (pi[c] | pr[c] | pw[c])) g = c;
        end
        if (g < 0) begin
            sample(PH_IDLE, 0, 0);
            tick();
            return;
        end
        ph = pw[g] ? PH_DW : (pr[g] ? PH_SN : PH_IF);
        o = -1;
        for (int c = 0; c < N; c++) begin
            if (o < 0 && c != g && bus.ccdirty[c]) o = c;
        end
        kind = (ph == PH_DW) ? "data write" : (ph == PH_IF) ? "ifetch" :
               (o >= 0) ? $sformatf("data read from cache %0d", o) : "data read from ram";
        n_txn++;
        $display("txn %0d: cache %0d %s%s", n_txn, g, kind, drop_snoop && ph == PH_SN ? " (dropped in snoop)" : "");
        sample(PH_IDLE, 0, 0);
        tick();
        if (ph == PH_SN) begin
            bus.ramstate = ST_FREE;
            if (drop_snoop) begin
                pr[g] = 1'b0;
                drive();
            end
            sample(PH_SN, g, 0);
            tick();
            ph = (o >= 0) ? PH_C2C : PH_M2C;
            if (o < 0) o = 0;
            if (drop_snoop) begin
                sample(ph, g, o);
                tick();
                rr = (g + 1) % N;
                return;
            end
        end
        if (o < 0) o = 0;
        b = (busy_n < 0) ? int'($urandom_range(0, 3)) : busy_n;
        for (int k = 0; k < b; k++) begin
            bus.ramstate = ($urandom_range(0, 3) == 0) ? ST_ERROR : ST_BUSY;
            bus.ramload  = $urandom;
            sample(ph, g, o);
            tick();
        end
        bus.ramstate = ST_ACCESS;
        bus.ramload  = fix_load ? 32'hDEADBEEF : $urandom;
        sample(ph, g, o);
        tick();
        case (ph)
            PH_IF:   pi[g] = 1'b0;
            PH_DW:   pw[g] = 1'b0;
            default: pr[g] = 1'b0;
        endcase
        drive();
        bus.ramstate = ST_FREE;
        sample(ph, g, o);
        tick();
        rr = (g + 1) % N;
    endtask

    task automatic drain();
        for (int k = 0; k < 3 * N && (pi | pr | pw) != '0; k++) begin
            rand_fields();
            run_txn(-1, 1'b0);
        end
    endtask

    initial begin
        pi = '0; pr = '0; pw = '0; rr = 0; fix_load = 1'b0;
        bus.ramstate = ST_FREE;
        bus.ramload  = '0;
        rand_fields();

        // Reset held with requests present: every output must be 0
        pi = 4'b1010; pr = 4'b0101; drive();
        sample(PH_RST, 0, 0);
        pi = '0; pr = '0; drive();
        tick();
        rst_n = 1'b1;
        sample(PH_IDLE, 0, 0);
        tick();

        // Caches 1 then 1+3 requesting ifetch. After the first grant the
        // pointer is 2, so cache 3 is served before cache 1.
        rand_fields(); pi = 4'b0010; drive(); run_txn(-1, 1'b0);
        rand_fields(); pi = 4'b1010; drive(); run_txn(-1, 1'b0);
        run_txn(-1, 1'b0);

        // Cache 0 reads with intent to modify, cache 2 owns the line dirty
        rand_fields();
        bus.ccwrite  = 4'b0001; bus.ccdirty = 4'b0100;
        bus.daddr[0] = 32'h100; bus.daddr[2] = 32'h100;
        pr = 4'b0001; drive(); run_txn(1, 1'b0);

        // Cache 1 reads from RAM: two BUSY cycles, then ACCESS with DEADBEEF
        rand_fields(); bus.ccdirty = '0; fix_load = 1'b1;
        pr = 4'b0010; drive(); run_txn(2, 1'b0);
        fix_load = 1'b0;

        // Cache 0 raises all three requests at once, cache 1 raises ifetch
        rand_fields();
        pi = 4'b0011; pr = 4'b0001; pw = 4'b0001; drive();
        drain();

        // Every cache fetches continuously: strict rotation over 3*N grants
        for (int t = 0; t < 3 * N; t++) begin
            rand_fields(); pi = '1; drive(); run_txn(-1, 1'b0);
        end
        pi = '0; drive();
        sample(PH_IDLE, 0, 0); tick();

        // Requester drops during the snoop cycle
        rand_fields(); pr = 4'b0100; drive(); run_txn(-1, 1'b1);

        // Random mix of requests, owners and RAM latencies
        for (int t = 0; t < 40; t++) begin
            rand_fields();
            pi = pi | 4'($urandom_range(0, 15));
            pr = pr | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            pw = pw | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            drive();
            run_txn(-1, $urandom_range(0, 7) == 0);
        end
        drain();

        // Reset in the middle of a RAM read while RAM reports BUSY
        rand_fields(); bus.ccdirty = '0;
        pr = 4'b0100; drive();
        $display("txn %0d: cache 2 data read from ram, reset while busy", n_txn + 1);
        n_txn++;
        sample(PH_IDLE, 0, 0); tick();
        sample(PH_SN, 2, 0);   tick();
        bus.ramstate = ST_BUSY;
        sample(PH_M2C, 2, 0);
        rst_n = 1'b0;
        #1;
        expect_cycle(PH_RST, 0, 0);
        pr = '0; drive();
        tick();
        rst_n = 1'b1;
        rr = 0;
        bus.ramstate = ST_FREE;
        for (int k = 0; k < 3; k++) begin
            sample(PH_IDLE, 0, 0);
            tick();
        end

        // The pointer restarts at 0 after reset
        rand_fields(); pi = 4'b1001; drive();
        run_txn(-1, 1'b0);
        run_txn(-1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
